ctrl_decode_stage: RTL and testbench
====================================

# ctrl_decode_stage

Registered, handshaked decode stage for the RISC-V core. It combines opcode-level control decode with funct3/funct7 ALU decode into one control bundle held in a one-entry pipeline register between fetch and execute. It also adds illegal-instruction detection, flush, and a hold state that serialises M-extension ops against an external multi-cycle mul/div unit.

## Interface
- ALUCTL_W, default 4: width of ALUControl (must be ≥4).
- EN_MEXT, default 1: 1 decodes funct7=0000001 R-type as M-extension; 0 flags it illegal.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  instr valid from fetch.
- in_ready  out  1  stage can accept instr this cycle.
- instr  in  32  instruction word.
- flush  in  1  discard held instruction (branch redirect).
- out_valid  out  1  control bundle valid to execute.
- out_ready  in  1  execute accepts bundle.
- md_done  in  1  one-cycle pulse from mul/div unit on completion.
- out_instr  out  32  registered instr.
- RegWrite, ALUSrc, SrcAPC, MemWrite, Branch, Jump, MulDiv, Illegal  out  1 each.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- ResultSrc  out  2  00 ALU, 01 mem, 10 PC+4.
- ALUControl  out  ALUCTL_W  operation code.

## Operation
- ALUControl codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10, MD 11; zero-extended to ALUCTL_W.
- Opcode map:
  - LW (0000011): RegWrite, ALUSrc, ImmSrc I, ResultSrc 01, ADD.
  - SW (0100011): MemWrite, ALUSrc, ImmSrc S, ADD.
  - R (0110011): RegWrite, funct-decoded.
  - I-arith (0010011): RegWrite, ALUSrc, ImmSrc I, funct-decoded.
  - B (1100011): Branch, ImmSrc B; funct3 000/001 → SUB, 100/101 → SLT, 110/111 → SLTU.
  - JAL (1101111): RegWrite, Jump, ImmSrc J, ResultSrc 10.
  - JALR (1100111): RegWrite, Jump, ALUSrc, ImmSrc I, ResultSrc 10, ADD.
  - LUI (0110111): RegWrite, ALUSrc, ImmSrc U, PASSB.
  - AUIPC (0010111): RegWrite, ALUSrc, SrcAPC, ImmSrc U, ADD.
- Funct decode: funct3 000 ADD, or SUB when R-type with funct7[5]=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7[5]=1; 110 OR; 111 AND.
- R-type with funct7=0000001 and EN_MEXT=1: MulDiv=1, ALUControl MD, RegWrite=1.
- Illegal (Illegal=1, all other control bits 0, bundle still handed off):
  - unknown opcode;
  - R-type funct7 not in {0000000, 0100000, 0000001 when EN_MEXT};
  - funct7=0100000 with funct3 other than 000/101;
  - I-type shift with instr[31:25] not in {0000000, 0100000 (101 only)}.
- FSM states: EMPTY, FULL, WAIT_MD.
  - EMPTY: in_valid → capture instr, go to FULL.
  - FULL, out_ready, held op non-MulDiv: if in_valid, capture new instr and stay FULL; otherwise go to EMPTY.
  - FULL, out_ready, held op MulDiv: go to WAIT_MD; no capture.
  - WAIT_MD: md_done → EMPTY.
- in_ready = EMPTY, or (FULL and out_ready and held op not MulDiv). It depends combinationally on out_ready.
- flush: FULL/EMPTY → EMPTY next edge; overrides in_valid in the same cycle. Ignored in WAIT_MD, because the op is already issued.
- A bundle is captured only on an in_valid&&in_ready edge. Control outputs change only on capture.

## Timing
- Reset values: all outputs 0, state EMPTY, in_ready=1 (combinational).
- Latency: instr accepted at edge N → out_valid and bundle at N+1.
- Throughput: 1 instr/cycle with out_ready held high.
- out_valid=1 only in FULL. Bundle is stable while out_valid && !out_ready.
- MulDiv hold: in_ready=0 from the handoff edge until the edge that samples md_done. Earliest next capture is the edge after that.
- md_done outside WAIT_MD is ignored.
- rst low mid-operation: immediate return to EMPTY, all outputs 0, any WAIT_MD abandoned.

## Structure
- Shared package holds: opcode constants, the ALUControl code constants, ImmSrc/ResultSrc encodings, and state encodings.
- Natural sub-module: ctrl_decode_comb, a purely combinational instr → bundle + Illegal decoder. The top level holds the FSM and output registers.

## Test plan
- add 0x002081B3, then sub 0x402081B3, back-to-back with out_ready=1 → consecutive bundles at N+1/N+2: RegWrite=1, ALUControl 0 then 1, in_ready stays 1.
- lw 0x0080A283 with out_ready=0 for 3 cycles → bundle (ResultSrc 01, ALUSrc 1, ADD) held stable, in_ready=0 until out_ready=1.
- mul 0x022081B3 (EN_MEXT=1) handed off → state WAIT_MD, in_ready=0; md_done on cycle 5 → next instr accepted on cycle 6. With EN_MEXT=0 → Illegal=1, no hold.
- 0xFFFFFFFF → out_valid=1, Illegal=1, all other control bits 0.
- beq 0x00208463 captured, flush asserted with in_valid the same cycle → EMPTY, out_valid=0, new instr not captured.
- rst driven low while in WAIT_MD → all outputs 0 asynchronously; after release, in_ready=1.

Source files
------------

// File: rtl/ctrl_decode_stage_pkg.sv
// Shared encodings for the decode stage: opcodes, ALU op codes, immediate/result
// selects, FSM states and the registered control bundle.
package ctrl_decode_stage_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
  localparam logic [3:0] ALU_MD    = 4'd11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_WAIT_MD} state_t;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       src_a_pc;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       mul_div;
    logic       illegal;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic [3:0] alu_ctl;
  } ctrl_t;

  // alt selects SUB (R-type only) or SRA; f3 is funct3.
  function automatic logic [3:0] funct_alu(input logic [2:0] f3, input logic alt,
                                           input logic is_r);
    case (f3)
      3'b000:  funct_alu = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  funct_alu = ALU_SLL;
      3'b010:  funct_alu = ALU_SLT;
      3'b011:  funct_alu = ALU_SLTU;
      3'b100:  funct_alu = ALU_XOR;
      3'b101:  funct_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  funct_alu = ALU_OR;
      default: funct_alu = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode_stage_comb.sv
// Purely combinational instruction decoder: instr -> control bundle with
// illegal-instruction detection.
module ctrl_decode_comb
  import ctrl_decode_stage_pkg::*;
#(
  parameter int EN_MEXT = 1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       bad;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    ctrl = '0;
    bad  = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.imm_src    = IMM_I;
        ctrl.result_src = RES_MEM;
        ctrl.alu_ctl    = ALU_ADD;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
        ctrl.alu_ctl   = ALU_ADD;
      end
      OP_R: begin
        ctrl.reg_write = 1'b1;
        case (f7)
          7'b0000000: ctrl.alu_ctl = funct_alu(f3, 1'b0, 1'b1);
          7'b0100000: begin
            if (f3 == 3'b000 || f3 == 3'b101) ctrl.alu_ctl = funct_alu(f3, 1'b1, 1'b1);
            else bad = 1'b1;
          end
          7'b0000001: begin
            if (EN_MEXT != 0) begin
              ctrl.mul_div = 1'b1;
              ctrl.alu_ctl = ALU_MD;
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_ctl   = funct_alu(f3, instr[30], 1'b0);
        // Only shifts reserve the upper immediate bits as funct7.
        if (f3 == 3'b001 && f7 != 7'b0000000) bad = 1'b1;
        if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) bad = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.imm_src = IMM_B;
        case (f3[2:1])
          2'b10:   ctrl.alu_ctl = ALU_SLT;
          2'b11:   ctrl.alu_ctl = ALU_SLTU;
          default: ctrl.alu_ctl = ALU_SUB;
        endcase
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.imm_src    = IMM_J;
        ctrl.result_src = RES_PC4;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.imm_src    = IMM_I;
        ctrl.result_src = RES_PC4;
        ctrl.alu_ctl    = ALU_ADD;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.alu_ctl   = ALU_PASSB;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.src_a_pc  = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.alu_ctl   = ALU_ADD;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered, handshaked decode stage: one-entry control bundle register with
// flush and a hold state that serialises M-extension ops.
module ctrl_decode_stage
  import ctrl_decode_stage_pkg::*;
#(
  parameter int ALUCTL_W = 4,
  parameter int EN_MEXT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                md_done,
  output logic [31:0]         out_instr,
  output logic                RegWrite,
  output logic                ALUSrc,
  output logic                SrcAPC,
  output logic                MemWrite,
  output logic                Branch,
  output logic                Jump,
  output logic                MulDiv,
  output logic                Illegal,
  output logic [2:0]          ImmSrc,
  output logic [1:0]          ResultSrc,
  output logic [ALUCTL_W-1:0] ALUControl
);

  state_t state, state_nx;
  ctrl_t  dec, held;
  logic   capture;

  ctrl_decode_comb #(.EN_MEXT(EN_MEXT)) u_dec (
    .instr (instr),
    .ctrl  (dec)
  );

  always_comb begin
    in_ready = (state == ST_EMPTY) || (state == ST_FULL && out_ready && !held.mul_div);
    // flush wins over a same-cycle in_valid.
    capture  = in_valid && in_ready && !flush;
    state_nx = state;
    case (state)
      ST_EMPTY: if (capture) state_nx = ST_FULL;
      ST_FULL: begin
        if (flush)               state_nx = ST_EMPTY;
        else if (out_ready) begin
          if (held.mul_div)      state_nx = ST_WAIT_MD;
          else if (!capture)     state_nx = ST_EMPTY;
        end
      end
      ST_WAIT_MD: if (md_done) state_nx = ST_EMPTY;
      default:    state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      held      <= '0;
      out_instr <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        held      <= dec;
        out_instr <= instr;
      end
    end
  end

  assign out_valid  = (state == ST_FULL);
  assign RegWrite   = held.reg_write;
  assign ALUSrc     = held.alu_src;
  assign SrcAPC     = held.src_a_pc;
  assign MemWrite   = held.mem_write;
  assign Branch     = held.branch;
  assign Jump       = held.jump;
  assign MulDiv     = held.mul_div;
  assign Illegal    = held.illegal;
  assign ImmSrc     = held.imm_src;
  assign ResultSrc  = held.result_src;
  assign ALUControl = ALUCTL_W'(held.alu_ctl);

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed self-checking bench for ctrl_decode_stage (EN_MEXT=1 main instance,
// EN_MEXT=0 side instance sharing the same stimulus).
module tb_ctrl_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready, md_done;
  logic [31:0] instr;

  logic        in_ready, out_valid, RegWrite, ALUSrc, SrcAPC, MemWrite, Branch, Jump;
  logic        MulDiv, Illegal;
  logic [31:0] out_instr;
  logic [2:0]  ImmSrc;
  logic [1:0]  ResultSrc;
  logic [3:0]  ALUControl;

  logic        in_ready2, out_valid2, RegWrite2, ALUSrc2, SrcAPC2, MemWrite2, Branch2, Jump2;
  logic        MulDiv2, Illegal2;
  logic [31:0] out_instr2;
  logic [2:0]  ImmSrc2;
  logic [1:0]  ResultSrc2;
  logic [3:0]  ALUControl2;

  // {RegWrite,ALUSrc,SrcAPC,MemWrite,Branch,Jump,MulDiv,Illegal,ImmSrc,ResultSrc,ALUControl}
  logic [16:0] obs, obs2;
  assign obs  = {RegWrite, ALUSrc, SrcAPC, MemWrite, Branch, Jump, MulDiv, Illegal,
                 ImmSrc, ResultSrc, ALUControl};
  assign obs2 = {RegWrite2, ALUSrc2, SrcAPC2, MemWrite2, Branch2, Jump2, MulDiv2, Illegal2,
                 ImmSrc2, ResultSrc2, ALUControl2};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.ALUCTL_W(4), .EN_MEXT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .md_done(md_done),
    .out_instr(out_instr), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .SrcAPC(SrcAPC),
    .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump), .MulDiv(MulDiv), .Illegal(Illegal),
    .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .ALUControl(ALUControl)
  );

  ctrl_decode_stage #(.ALUCTL_W(4), .EN_MEXT(0)) dut_nom (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .instr(instr),
    .flush(flush), .out_valid(out_valid2), .out_ready(out_ready), .md_done(md_done),
    .out_instr(out_instr2), .RegWrite(RegWrite2), .ALUSrc(ALUSrc2), .SrcAPC(SrcAPC2),
    .MemWrite(MemWrite2), .Branch(Branch2), .Jump(Jump2), .MulDiv(MulDiv2),
    .Illegal(Illegal2), .ImmSrc(ImmSrc2), .ResultSrc(ResultSrc2), .ALUControl(ALUControl2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; md_done = 1'b0;
    instr = '0;
    #12;
    n_checks++;
    if ({out_valid, obs, out_instr} !== 50'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", {out_valid, obs, out_instr});
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h002081B3;
    tick();
    instr = 32'h402081B3;
    #1;
    n_checks++;
    if ({out_valid, obs} !== {1'b1, 8'b1000_0000, 3'b000, 2'b00, 4'd0}) begin
      n_fail++; $display("FAIL b2b_add got %b want %b", {out_valid, obs},
                         {1'b1, 8'b1000_0000, 3'b000, 2'b00, 4'd0});
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_in_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, obs, out_instr} !== {1'b1, 8'b1000_0000, 3'b000, 2'b00, 4'd1, 32'h402081B3}) begin
      n_fail++; $display("FAIL b2b_sub got %h want %h", {out_valid, obs, out_instr},
                         {1'b1, 8'b1000_0000, 3'b000, 2'b00, 4'd1, 32'h402081B3});
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h0080A283;
    tick();
    instr = 32'h002081B3;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({out_valid, in_ready, obs, out_instr} !==
          {1'b1, 1'b0, 8'b1100_0000, 3'b000, 2'b01, 4'd0, 32'h0080A283}) begin
        n_fail++; $display("FAIL stall_hold[%0d] got %h want %h", i,
                           {out_valid, in_ready, obs, out_instr},
                           {1'b1, 1'b0, 8'b1100_0000, 3'b000, 2'b01, 4'd0, 32'h0080A283});
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release_in_ready got %b want 1", in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_instr} !== {1'b0, 32'h0080A283}) begin
      n_fail++; $display("FAIL stall_drain got %h want %h", {out_valid, out_instr},
                         {1'b0, 32'h0080A283});
    end
  endtask

  task automatic test_muldiv();
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h022081B3;
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, obs} !== {1'b1, 1'b0, 8'b1000_0010, 3'b000, 2'b00, 4'd11}) begin
      n_fail++; $display("FAIL md_bundle got %b want %b", {out_valid, in_ready, obs},
                         {1'b1, 1'b0, 8'b1000_0010, 3'b000, 2'b00, 4'd11});
    end
    n_checks++;
    if ({out_valid2, in_ready2, obs2} !== {1'b1, 1'b1, 8'b0000_0001, 3'b000, 2'b00, 4'd0}) begin
      n_fail++; $display("FAIL md_nomext_illegal got %b want %b", {out_valid2, in_ready2, obs2},
                         {1'b1, 1'b1, 8'b0000_0001, 3'b000, 2'b00, 4'd0});
    end
    tick();
    in_valid = 1'b1; instr = 32'h0020C1B3;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
        n_fail++; $display("FAIL md_wait[%0d] got %b want 00", i, {out_valid, in_ready});
      end
      tick();
    end
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, out_instr} !== {1'b0, 1'b1, 32'h022081B3}) begin
      n_fail++; $display("FAIL md_done_release got %h want %h", {out_valid, in_ready, out_instr},
                         {1'b0, 1'b1, 32'h022081B3});
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, obs, out_instr} !== {1'b1, 8'b1000_0000, 3'b000, 2'b00, 4'd4, 32'h0020C1B3}) begin
      n_fail++; $display("FAIL md_next_capture got %h want %h", {out_valid, obs, out_instr},
                         {1'b1, 8'b1000_0000, 3'b000, 2'b00, 4'd4, 32'h0020C1B3});
    end
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL md_stray_done got %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_decode_table();
    logic [31:0] vec [12];
    logic [16:0] exp [12];
    vec[0]  = 32'hFFFFFFFF; exp[0]  = {8'b0000_0001, 3'b000, 2'b00, 4'd0};
    vec[1]  = 32'h402091B3; exp[1]  = {8'b0000_0001, 3'b000, 2'b00, 4'd0};
    vec[2]  = 32'h40209093; exp[2]  = {8'b0000_0001, 3'b000, 2'b00, 4'd0};
    vec[3]  = 32'h4020D093; exp[3]  = {8'b1100_0000, 3'b000, 2'b00, 4'd9};
    vec[4]  = 32'h0020C463; exp[4]  = {8'b0000_1000, 3'b010, 2'b00, 4'd5};
    vec[5]  = 32'h008000EF; exp[5]  = {8'b1000_0100, 3'b011, 2'b10, 4'd0};
    vec[6]  = 32'h123450B7; exp[6]  = {8'b1100_0000, 3'b100, 2'b00, 4'd10};
    vec[7]  = 32'h00001097; exp[7]  = {8'b1110_0000, 3'b100, 2'b00, 4'd0};
    vec[8]  = 32'h0020A423; exp[8]  = {8'b0101_0000, 3'b001, 2'b00, 4'd0};
    vec[9]  = 32'h000080E7; exp[9]  = {8'b1100_0100, 3'b000, 2'b10, 4'd0};
    vec[10] = 32'h0020C1B3; exp[10] = {8'b1000_0000, 3'b000, 2'b00, 4'd4};
    vec[11] = 32'h80008093; exp[11] = {8'b1100_0000, 3'b000, 2'b00, 4'd0};
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      instr = vec[i];
      tick();
      n_checks++;
      if ({out_valid, obs} !== {1'b1, exp[i]}) begin
        n_fail++; $display("FAIL decode[%0d] instr %h got %b want %b", i, vec[i],
                           {out_valid, obs}, {1'b1, exp[i]});
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00208463;
    tick();
    n_checks++;
    if ({out_valid, obs} !== {1'b1, 8'b0000_1000, 3'b010, 2'b00, 4'd1}) begin
      n_fail++; $display("FAIL flush_beq got %b want %b", {out_valid, obs},
                         {1'b1, 8'b0000_1000, 3'b010, 2'b00, 4'd1});
    end
    out_ready = 1'b1; instr = 32'h002081B3; flush = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, obs, out_instr} !== {1'b0, 8'b0000_1000, 3'b010, 2'b00, 4'd1, 32'h00208463}) begin
      n_fail++; $display("FAIL flush_full got %h want %h", {out_valid, obs, out_instr},
                         {1'b0, 8'b0000_1000, 3'b010, 2'b00, 4'd1, 32'h00208463});
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_instr} !== {1'b0, 32'h00208463}) begin
      n_fail++; $display("FAIL flush_empty got %h want %h", {out_valid, out_instr},
                         {1'b0, 32'h00208463});
    end
  endtask

  task automatic test_reset_in_wait_md();
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h022081B3;
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, in_ready, MulDiv} !== 3'b001) begin
      n_fail++; $display("FAIL rst_wait_pre got %b want 001", {out_valid, in_ready, MulDiv});
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, obs, out_instr, in_ready} !== {50'd0, 1'b1}) begin
      n_fail++; $display("FAIL rst_wait_async got %h want %h",
                         {out_valid, obs, out_instr, in_ready}, {50'd0, 1'b1});
    end
    #1 rst = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rst_wait_release got %b want 01", {out_valid, in_ready});
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_muldiv();
    test_decode_table();
    test_flush();
    test_reset_in_wait_md();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
